// File: rtl/serial_adder_if.sv
// serial_adder handshake/operand bundle.
// Master drives the request, slave returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             Sub;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] S;
  logic             Co;
  logic             Ovf;

  modport master (
    output Start, A, B, Ci, Sub,
    input  Busy, Done, S, Co, Ovf
  );

  modport slave (
    input  Start, A, B, Ci, Sub,
    output Busy, Done, S, Co, Ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock,
// registered carry between digits, LSB digit first.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           Clk,
  input  logic           Rst_n,
  serial_adder_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 2");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_co;
  logic             r_ovf;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0]       w_sum;
  logic                   w_cout;
  logic                   w_cin_top;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_nx;
  logic                   w_last;
  logic                   w_load;
  logic                   w_fin;
  logic                   w_busy;

  // Ripple chain across one digit; w_cin_top is the carry
  // into the digit's top bit, which is the MSB on the last digit.
  always_comb begin
    logic v_c;
    v_c       = r_c;
    w_sum     = '0;
    w_cin_top = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      w_cin_top = v_c;
      w_sum[i]  = r_a[i] ^ r_b[i] ^ v_c;
      v_c       = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_cout = v_c;
  end

  assign w_cat    = {w_sum, r_res};
  assign w_res_nx = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_last   = (r_cnt == CW'(N - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_fin      = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_load     = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_fin = 1'b1;
          if (bus.Start) w_load     = 1'b1;
          else           w_state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_s    <= '0;
      r_co   <= 1'b0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_a   <= bus.A;
        r_b   <= bus.Sub ? ~bus.B : bus.B;
        r_c   <= bus.Ci ^ bus.Sub;
        r_res <= '0;
        r_cnt <= '0;
      end else if (w_busy) begin
        r_a   <= r_a >> DIGIT;
        r_b   <= r_b >> DIGIT;
        r_c   <= w_cout;
        r_res <= w_res_nx;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fin) begin
        r_s   <= w_res_nx;
        r_co  <= w_cout;
        r_ovf <= w_cin_top ^ w_cout;
      end
    end
  end

  assign bus.Busy = w_busy;
  assign bus.Done = r_done;
  assign bus.S    = r_s;
  assign bus.Co   = r_co;
  assign bus.Ovf  = r_ovf;

endmodule
